// File: rtl/sdram_request_arbiter.sv
// Two-channel round-robin arbiter in front of the SDRAM controller command port.
// One command in flight; read data routed back to the issuing channel.
module sdram_request_arbiter #(
    parameter int ADDR_W         = 25,
    parameter int DATA_W         = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                  clock_50Mhz,
    input  logic                  reset,

    input  logic [1:0]            req_valid,
    input  logic [1:0]            req_isWriting,
    input  logic [2*ADDR_W-1:0]   req_address,
    input  logic [2*DATA_W-1:0]   req_writeData,
    output logic [1:0]            req_ack,

    output logic [1:0]            rd_valid,
    output logic [DATA_W-1:0]     rd_data,

    output logic [ADDR_W-1:0]     sdram_inputAddress,
    output logic [DATA_W-1:0]     sdram_writeData,
    output logic                  sdram_isWriting,
    output logic                  sdram_inputValid,
    input  logic                  sdram_recievedCommand,
    input  logic                  sdram_outputValid,
    input  logic [DATA_W-1:0]     sdram_readData,
    input  logic                  sdram_isBusy,

    output logic                  grant_owner,
    output logic                  arb_busy,
    output logic                  timeout_error
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_READ = 2'd2
    } arbState_t;

    localparam int TIMER_W =
        (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TIMER_W-1:0] TIMER_LAST =
        TIMER_W'(TIMEOUT_CYCLES - 1);

    arbState_t          state;
    logic               lastGrant;
    logic [TIMER_W-1:0] readTimer;

    logic               winner;
    logic [ADDR_W-1:0]  winnerAddress;
    logic [DATA_W-1:0]  winnerData;
    logic               winnerIsWriting;
    logic [1:0]         ownerMask;

    // Pick the channel to serve: alternate under contention, else the lone requester.
    always_comb begin
        winner          = 1'b0;
        winnerAddress   = '0;
        winnerData      = '0;
        winnerIsWriting = 1'b0;
        if (req_valid == 2'b11) begin
            winner = ~lastGrant;
        end else begin
            winner = req_valid[1];
        end
        if (winner) begin
            winnerAddress   = req_address[2*ADDR_W-1:ADDR_W];
            winnerData      = req_writeData[2*DATA_W-1:DATA_W];
            winnerIsWriting = req_isWriting[1];
        end else begin
            winnerAddress   = req_address[ADDR_W-1:0];
            winnerData      = req_writeData[DATA_W-1:0];
            winnerIsWriting = req_isWriting[0];
        end
    end

    // One-hot view of the owning channel, used for ack and read-data routing.
    always_comb begin
        ownerMask = grant_owner ? 2'b10 : 2'b01;
    end

    // Arbitration FSM; every output is a register so the controller sees clean levels.
    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state              <= IDLE;
            lastGrant          <= 1'b1;
            readTimer          <= '0;
            req_ack            <= 2'b00;
            rd_valid           <= 2'b00;
            rd_data            <= '0;
            sdram_inputAddress <= '0;
            sdram_writeData    <= '0;
            sdram_isWriting    <= 1'b0;
            sdram_inputValid   <= 1'b0;
            grant_owner        <= 1'b0;
            arb_busy           <= 1'b0;
            timeout_error      <= 1'b0;
        end else begin
            req_ack  <= 2'b00;
            rd_valid <= 2'b00;

            case (state)
                IDLE: begin
                    if ((req_valid != 2'b00) && !sdram_isBusy) begin
                        sdram_inputAddress <= winnerAddress;
                        sdram_writeData    <= winnerData;
                        sdram_isWriting    <= winnerIsWriting;
                        sdram_inputValid   <= 1'b1;
                        grant_owner        <= winner;
                        lastGrant          <= winner;
                        arb_busy           <= 1'b1;
                        state              <= ISSUE;
                    end
                end

                ISSUE: begin
                    if (sdram_recievedCommand) begin
                        sdram_inputValid <= 1'b0;
                        req_ack          <= ownerMask;
                        if (sdram_isWriting) begin
                            arb_busy <= 1'b0;
                            state    <= IDLE;
                        end else begin
                            readTimer <= '0;
                            state     <= WAIT_READ;
                        end
                    end
                end

                WAIT_READ: begin
                    if (sdram_outputValid) begin
                        rd_data  <= sdram_readData;
                        rd_valid <= ownerMask;
                        arb_busy <= 1'b0;
                        state    <= IDLE;
                    end else if (readTimer == TIMER_LAST) begin
                        timeout_error <= 1'b1;
                        arb_busy      <= 1'b0;
                        state         <= IDLE;
                    end else begin
                        readTimer <= readTimer + 1'b1;
                    end
                end

                default: begin
                    sdram_inputValid <= 1'b0;
                    arb_busy         <= 1'b0;
                    state            <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_request_arbiter.sv
// Directed bench for sdram_request_arbiter.
// Ack and read-data events are scoreboarded against expectations queued at stimulus time.
module tb_sdram_request_arbiter;

    localparam int ADDR_W = 25;
    localparam int DATA_W = 16;
    localparam int TMO    = 1024;

    logic                clock_50Mhz = 1'b0;
    logic                reset;
    logic [1:0]          req_valid;
    logic [1:0]          req_isWriting;
    logic [2*ADDR_W-1:0] req_address;
    logic [2*DATA_W-1:0] req_writeData;
    logic [1:0]          req_ack;
    logic [1:0]          rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic [ADDR_W-1:0]   sdram_inputAddress;
    logic [DATA_W-1:0]   sdram_writeData;
    logic                sdram_isWriting;
    logic                sdram_inputValid;
    logic                sdram_recievedCommand;
    logic                sdram_outputValid;
    logic [DATA_W-1:0]   sdram_readData;
    logic                sdram_isBusy;
    logic                grant_owner;
    logic                arb_busy;
    logic                timeout_error;

    typedef struct {
        int                ch;
        logic [DATA_W-1:0] data;
    } rdExp_t;

    int     ackQ[$];
    rdExp_t rdQ[$];
    int     testCount = 0;
    int     failCount = 0;

    sdram_request_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clock_50Mhz(clock_50Mhz),
        .reset(reset),
        .req_valid(req_valid),
        .req_isWriting(req_isWriting),
        .req_address(req_address),
        .req_writeData(req_writeData),
        .req_ack(req_ack),
        .rd_valid(rd_valid),
        .rd_data(rd_data),
        .sdram_inputAddress(sdram_inputAddress),
        .sdram_writeData(sdram_writeData),
        .sdram_isWriting(sdram_isWriting),
        .sdram_inputValid(sdram_inputValid),
        .sdram_recievedCommand(sdram_recievedCommand),
        .sdram_outputValid(sdram_outputValid),
        .sdram_readData(sdram_readData),
        .sdram_isBusy(sdram_isBusy),
        .grant_owner(grant_owner),
        .arb_busy(arb_busy),
        .timeout_error(timeout_error)
    );

    always #10 clock_50Mhz = ~clock_50Mhz;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        testCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        int e;
        rdExp_t r;
        if (req_ack !== 2'b00) begin
            if (ackQ.size() == 0) begin
                check("ack_unexpected", 64'(req_ack), 64'd0);
            end else begin
                e = ackQ.pop_front();
                check("sb_ack", 64'(req_ack), 64'(2'b01 << e));
            end
        end
        if (rd_valid !== 2'b00) begin
            if (rdQ.size() == 0) begin
                check("rd_unexpected", 64'(rd_valid), 64'd0);
            end else begin
                r = rdQ.pop_front();
                check("sb_rd", {46'd0, rd_valid, rd_data},
                      {46'd0, 2'(2'b01 << r.ch), r.data});
            end
        end
    endtask

    task automatic step();
        @(negedge clock_50Mhz);
        monitor();
    endtask

    task automatic setReq(input int ch, input logic v, input logic wr,
                          input logic [ADDR_W-1:0] a,
                          input logic [DATA_W-1:0] d);
        req_valid[ch]                  = v;
        req_isWriting[ch]              = wr;
        req_address[ch*ADDR_W +: ADDR_W] = a;
        req_writeData[ch*DATA_W +: DATA_W] = d;
    endtask

    task automatic pushRd(input int ch, input logic [DATA_W-1:0] d);
        rdExp_t r;
        r.ch   = ch;
        r.data = d;
        rdQ.push_back(r);
    endtask

    task automatic checkAllZero(input string tag);
        check({tag, "_ivalid"}, 64'(sdram_inputValid), 64'd0);
        check({tag, "_addr"}, 64'(sdram_inputAddress), 64'd0);
        check({tag, "_wdata"}, 64'(sdram_writeData), 64'd0);
        check({tag, "_iswr"}, 64'(sdram_isWriting), 64'd0);
        check({tag, "_ack"}, 64'(req_ack), 64'd0);
        check({tag, "_rdv"}, 64'(rd_valid), 64'd0);
        check({tag, "_rdata"}, 64'(rd_data), 64'd0);
        check({tag, "_owner"}, 64'(grant_owner), 64'd0);
        check({tag, "_busy"}, 64'(arb_busy), 64'd0);
        check({tag, "_tmo"}, 64'(timeout_error), 64'd0);
    endtask

    initial begin
        int owner;
        reset                 = 1'b1;
        req_valid             = '0;
        req_isWriting         = '0;
        req_address           = '0;
        req_writeData         = '0;
        sdram_recievedCommand = 1'b0;
        sdram_outputValid     = 1'b0;
        sdram_readData        = '0;
        sdram_isBusy          = 1'b0;

        // Reset state
        step();
        step();
        checkAllZero("reset");
        reset = 1'b0;

        // Ch0 write, accepted on the third clock of inputValid
        setReq(0, 1'b1, 1'b1, 25'h000010, 16'hBEEF);
        setReq(1, 1'b0, 1'b0, 25'h0000155, 16'h5555);
        ackQ.push_back(0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("w_ivalid", 64'(sdram_inputValid), 64'd1);
            check("w_addr", 64'(sdram_inputAddress), 64'h10);
            check("w_data", 64'(sdram_writeData), 64'hBEEF);
            check("w_iswr", 64'(sdram_isWriting), 64'd1);
            check("w_ack_early", 64'(req_ack), 64'd0);
            if (i == 0) begin
                check("w_owner", 64'(grant_owner), 64'd0);
                check("w_busy", 64'(arb_busy), 64'd1);
                setReq(0, 1'b1, 1'b1, 25'h000999, 16'h1111);
            end
            if (i == 2) sdram_recievedCommand = 1'b1;
        end
        step();
        check("w_ack", 64'(req_ack), 64'b01);
        check("w_ivalid_drop", 64'(sdram_inputValid), 64'd0);
        check("w_busy_drop", 64'(arb_busy), 64'd0);
        sdram_recievedCommand = 1'b0;
        req_valid = 2'b00;
        step();
        check("w_ack_pulse", 64'(req_ack), 64'd0);
        check("w_idle_ivalid", 64'(sdram_inputValid), 64'd0);

        // Round robin from reset: ch0, ch1, ch0
        reset = 1'b1;
        step();
        reset = 1'b0;
        setReq(0, 1'b1, 1'b1, 25'h000100, 16'hAAAA);
        setReq(1, 1'b1, 1'b1, 25'h000200, 16'hBBBB);
        for (int r = 0; r < 3; r++) begin
            owner = r % 2;
            ackQ.push_back(owner);
            step();
            check("rr_ivalid", 64'(sdram_inputValid), 64'd1);
            check("rr_owner", 64'(grant_owner), 64'(owner));
            check("rr_addr", 64'(sdram_inputAddress),
                  owner == 0 ? 64'h100 : 64'h200);
            sdram_recievedCommand = 1'b1;
            step();
            check("rr_ack", 64'(req_ack), 64'(2'b01 << owner));
            check("rr_idle", 64'(sdram_inputValid), 64'd0);
            sdram_recievedCommand = 1'b0;
        end
        req_valid = 2'b00;
        step();
        check("rr_busy_end", 64'(arb_busy), 64'd0);

        // Ch1 read, data returned 5 clocks after accept
        setReq(1, 1'b1, 1'b0, 25'h1ABCDE, 16'h0000);
        ackQ.push_back(1);
        pushRd(1, 16'h1234);
        step();
        check("rd_ivalid", 64'(sdram_inputValid), 64'd1);
        check("rd_iswr", 64'(sdram_isWriting), 64'd0);
        check("rd_addr", 64'(sdram_inputAddress), 64'h1ABCDE);
        sdram_recievedCommand = 1'b1;
        step();
        check("rd_ack", 64'(req_ack), 64'b10);
        sdram_recievedCommand = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rd_wait_rdv", 64'(rd_valid), 64'd0);
            check("rd_wait_busy", 64'(arb_busy), 64'd1);
        end
        sdram_outputValid = 1'b1;
        sdram_readData    = 16'h1234;
        step();
        check("rd_rdv", 64'(rd_valid), 64'b10);
        check("rd_data", 64'(rd_data), 64'h1234);
        sdram_outputValid = 1'b0;
        sdram_readData    = 16'h0000;
        step();
        check("rd_rdv_pulse", 64'(rd_valid), 64'd0);
        check("rd_data_hold", 64'(rd_data), 64'h1234);
        check("rd_busy_end", 64'(arb_busy), 64'd0);

        // Ch0 read that never returns
        setReq(0, 1'b1, 1'b0, 25'h000055, 16'h0000);
        ackQ.push_back(0);
        step();
        check("to_ivalid", 64'(sdram_inputValid), 64'd1);
        sdram_recievedCommand = 1'b1;
        step();
        check("to_ack", 64'(req_ack), 64'b01);
        sdram_recievedCommand = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < TMO - 1; i++) step();
        check("to_not_yet", 64'(timeout_error), 64'd0);
        check("to_busy_still", 64'(arb_busy), 64'd1);
        step();
        check("to_flag", 64'(timeout_error), 64'd1);
        check("to_idle", 64'(arb_busy), 64'd0);
        check("to_no_rdv", 64'(rd_valid), 64'd0);
        sdram_outputValid = 1'b1;
        sdram_readData    = 16'hDEAD;
        step();
        check("late_rdv", 64'(rd_valid), 64'd0);
        check("late_rdata", 64'(rd_data), 64'h1234);
        sdram_outputValid = 1'b0;
        setReq(1, 1'b1, 1'b1, 25'h000077, 16'hCAFE);
        ackQ.push_back(1);
        step();
        check("post_ivalid", 64'(sdram_inputValid), 64'd1);
        check("post_wdata", 64'(sdram_writeData), 64'hCAFE);
        sdram_recievedCommand = 1'b1;
        step();
        check("post_ack", 64'(req_ack), 64'b10);
        sdram_recievedCommand = 1'b0;
        req_valid = 2'b00;
        step();
        check("to_sticky", 64'(timeout_error), 64'd1);
        check("post_busy", 64'(arb_busy), 64'd0);

        // Controller busy holds off the grant
        sdram_isBusy = 1'b1;
        setReq(0, 1'b1, 1'b1, 25'h000033, 16'h4444);
        ackQ.push_back(0);
        for (int i = 0; i < 20; i++) begin
            step();
            check("busy_no_ivalid", 64'(sdram_inputValid), 64'd0);
        end
        check("busy_no_grant", 64'(arb_busy), 64'd0);
        sdram_isBusy = 1'b0;
        step();
        check("busy_grant", 64'(sdram_inputValid), 64'd1);
        check("busy_addr", 64'(sdram_inputAddress), 64'h33);
        sdram_recievedCommand = 1'b1;
        step();
        check("busy_ack", 64'(req_ack), 64'b01);
        sdram_recievedCommand = 1'b0;
        req_valid = 2'b00;
        step();

        // Reset while waiting for read data
        setReq(1, 1'b1, 1'b0, 25'h000042, 16'h0000);
        ackQ.push_back(1);
        step();
        check("rst_ivalid", 64'(sdram_inputValid), 64'd1);
        sdram_recievedCommand = 1'b1;
        step();
        check("rst_ack", 64'(req_ack), 64'b10);
        sdram_recievedCommand = 1'b0;
        req_valid = 2'b00;
        step();
        step();
        check("rst_waiting", 64'(arb_busy), 64'd1);
        reset = 1'b1;
        step();
        checkAllZero("midrst");
        reset = 1'b0;
        sdram_outputValid = 1'b1;
        sdram_readData    = 16'h9999;
        step();
        check("midrst_no_rdv", 64'(rd_valid), 64'd0);
        sdram_outputValid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("midrst_quiet", 64'({rd_valid, req_ack}), 64'd0);
        end

        check("ack_queue_empty", 64'(ackQ.size()), 64'd0);
        check("rd_queue_empty", 64'(rdQ.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
